// File: rtl/lsu_pkg.sv
// lsu_pkg: opcodes, funct3 encodings, FSM states and legality helpers for the load/store unit
package lsu_pkg;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        return is_store ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        return (f3[1:0] == F3_H[1:0]) ? !lo[0] : (f3[1:0] == F3_W[1:0]) ? (lo == 2'b00) : 1'b1;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane strobes, replicated write data and load extraction/extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    // steer store lanes and pick/extend the load lane; funct3[2] marks the unsigned loads
    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        wstrb_o  = (funct3_i[1:0] == F3_B[1:0]) ? (4'b0001 << addr_lo_i) :
                   (funct3_i[1:0] == F3_H[1:0]) ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o  = (funct3_i[1:0] == F3_B[1:0]) ? {4{store_data_i[7:0]}} :
                   (funct3_i[1:0] == F3_H[1:0]) ? {2{store_data_i[15:0]}} : store_data_i;
        ldata_o  = funct3_i[1] ? rdata_i :
                   funct3_i[0] ? {{16{~funct3_i[2] & half_sel[15]}}, half_sel} :
                                 {{24{~funct3_i[2] & byte_sel[7]}}, byte_sel};
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer with alignment checks and ack timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          fault_q, fault_d;
    logic [6:0]    opcode_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q, store_data_q, load_data_q;
    logic          accept, ok, is_store_q;
    logic [3:0]    strb;
    logic [31:0]   wdata, ldata;
    lsu_align u_align (
        .funct3_i    (funct3_q),
        .addr_lo_i   (addr_q[1:0]),
        .store_data_i(store_data_q),
        .rdata_i     (mem_rdata),
        .wstrb_o     (strb),
        .wdata_o     (wdata),
        .ldata_o     (ldata)
    );
    // decode the incoming request and drive the memory-side and status outputs from latched state
    always_comb begin
        accept     = (state_q == IDLE) && start && ((opcode == LOAD) || (opcode == STORE));
        ok         = f3_legal(opcode == STORE, funct3) && addr_aligned(funct3, addr[1:0]);
        is_store_q = (opcode_q == STORE);
        cnt_inc    = cnt_q + CW'(1);
        busy       = (state_q != IDLE);
        done       = (state_q == RESP);
        fault      = done && fault_q;
        mem_req    = (state_q == ACCESS);
        mem_we     = mem_req && is_store_q;
        mem_wstrb  = mem_we ? strb : 4'b0000;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata;
        load_data  = load_data_q;
    end
    // next state: faulting ops skip ACCESS; an ack beats a timeout landing in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = ok ? ACCESS : RESP;
                fault_d = !ok;
                cnt_d   = '0;
            end
            ACCESS: if (mem_ack) begin
                state_d = RESP;
                fault_d = 1'b0;
            end else begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == LIMIT) ? RESP : ACCESS;
                fault_d = (cnt_inc == LIMIT);
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // FSM state, wait counter and fault flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end
    // latch the operation on acceptance and capture load results on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q     <= '0;
            funct3_q     <= '0;
            addr_q       <= '0;
            store_data_q <= '0;
            load_data_q  <= '0;
        end else begin
            if (accept) begin
                opcode_q     <= opcode;
                funct3_q     <= funct3;
                addr_q       <= addr;
                store_data_q <= store_data;
            end
            if (mem_req && mem_ack && !is_store_q) load_data_q <= ldata;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit, default and short-timeout instances
module tb_load_store_unit;
    import lsu_pkg::*;
    logic        clk, rst, sel;
    logic        start_d, start_t, ack_d, ack_t;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rdata;
    logic        d_busy, d_done, d_fault, d_req, d_we;
    logic [31:0] d_ld, d_addr, d_wdata;
    logic [3:0]  d_strb;
    logic        t_busy, t_done, t_fault, t_req, t_we;
    logic [31:0] t_ld, t_addr, t_wdata;
    logic [3:0]  t_strb;
    logic        o_busy, o_done, o_fault, o_req, o_we;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_strb;
    int          n_chk, n_fail;
    int          r_dc, r_nreq;
    logic        r_flt, r_stable, r_idle, r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_strb;

    load_store_unit u_dut (
        .clk(clk), .rst(rst), .start(start_d), .opcode(opcode), .funct3(funct3), .addr(addr),
        .store_data(store_data), .busy(d_busy), .done(d_done), .fault(d_fault), .load_data(d_ld),
        .mem_req(d_req), .mem_we(d_we), .mem_addr(d_addr), .mem_wstrb(d_strb), .mem_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_ack(ack_d)
    );
    load_store_unit #(.TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .rst(rst), .start(start_t), .opcode(opcode), .funct3(funct3), .addr(addr),
        .store_data(store_data), .busy(t_busy), .done(t_done), .fault(t_fault), .load_data(t_ld),
        .mem_req(t_req), .mem_we(t_we), .mem_addr(t_addr), .mem_wstrb(t_strb), .mem_wdata(t_wdata),
        .mem_rdata(mem_rdata), .mem_ack(ack_t)
    );

    assign o_busy  = sel ? t_busy  : d_busy;
    assign o_done  = sel ? t_done  : d_done;
    assign o_fault = sel ? t_fault : d_fault;
    assign o_req   = sel ? t_req   : d_req;
    assign o_we    = sel ? t_we    : d_we;
    assign o_addr  = sel ? t_addr  : d_addr;
    assign o_wdata = sel ? t_wdata : d_wdata;
    assign o_strb  = sel ? t_strb  : d_strb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one op in cycle 0, ack in ACCESS cycle ack_at, optional busy-time start in cycle mid
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int ack_at, input int mid);
        opcode = op; funct3 = f3; addr = a; store_data = sd; mem_rdata = rd;
        r_dc = 0; r_nreq = 0; r_flt = 1'b0; r_stable = 1'b1;
        r_addr = '0; r_wdata = '0; r_strb = '0; r_we = 1'b0;
        if (sel) start_t = 1'b1; else start_d = 1'b1;
        tick();
        for (int c = 1; c < 400; c++) begin
            start_d = 1'b0; start_t = 1'b0;
            if (c == mid) begin
                opcode = LOAD; funct3 = F3_W; addr = 32'h3000;
                if (sel) start_t = 1'b1; else start_d = 1'b1;
            end
            if (o_done) begin
                r_dc = c; r_flt = o_fault;
                break;
            end
            if (o_req) begin
                if (r_nreq == 0) begin
                    r_addr = o_addr; r_wdata = o_wdata; r_strb = o_strb; r_we = o_we;
                end else if ({o_addr, o_wdata, o_strb, o_we} != {r_addr, r_wdata, r_strb, r_we}) begin
                    r_stable = 1'b0;
                end
                r_nreq++;
            end
            if (sel) ack_t = (c == ack_at); else ack_d = (c == ack_at);
            tick();
        end
        start_d = 1'b0; start_t = 1'b0; ack_d = 1'b0; ack_t = 1'b0;
        tick();
        r_idle = !o_busy && !o_done;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; sel = 1'b0;
        rst = 1'b1; start_d = 1'b0; start_t = 1'b0; ack_d = 1'b0; ack_t = 1'b0;
        opcode = '0; funct3 = '0; addr = '0; store_data = '0; mem_rdata = '0;
        repeat (2) tick();
        chk("rst_ctrl", {d_busy, d_done, d_fault, d_req, d_we, d_strb}, 32'h0);
        chk("rst_addr", d_addr, 32'h0);
        chk("rst_wdata", d_wdata, 32'h0);
        chk("rst_load_data", d_ld, 32'h0);
        rst = 1'b0;

        run_op(STORE, F3_B, 32'h1003, 32'h0000_00AB, 32'h0, 1, 0);
        chk("sb_done_cycle", r_dc, 2);
        chk("sb_fault", r_flt, 0);
        chk("sb_addr", r_addr, 32'h1000);
        chk("sb_strb", r_strb, 4'b1000);
        chk("sb_wdata", r_wdata, 32'hABAB_ABAB);
        chk("sb_we", r_we, 1);
        chk("sb_idle_after", r_idle, 1);

        run_op(STORE, F3_H, 32'h1002, 32'h0000_1234, 32'h0, 1, 0);
        chk("sh_strb", r_strb, 4'b1100);
        chk("sh_wdata", r_wdata, 32'h1234_1234);

        run_op(LOAD, F3_B, 32'h2001, 32'h0, 32'h0000_8000, 1, 0);
        chk("lb_data", d_ld, 32'hFFFF_FF80);
        chk("lb_we_strb", {r_we, r_strb}, 5'b0);
        chk("lb_done_cycle", r_dc, 2);
        run_op(LOAD, F3_BU, 32'h2001, 32'h0, 32'h0000_8000, 1, 0);
        chk("lbu_data", d_ld, 32'h0000_0080);

        run_op(LOAD, F3_W, 32'h2002, 32'h0, 32'h5555_5555, 1, 0);
        chk("lw_mis_done_cycle", r_dc, 1);
        chk("lw_mis_fault", r_flt, 1);
        chk("lw_mis_no_req", r_nreq, 0);
        chk("lw_mis_ld_kept", d_ld, 32'h0000_0080);
        run_op(LOAD, F3_H, 32'h2003, 32'h0, 32'h5555_5555, 1, 0);
        chk("lh_mis_done_cycle", r_dc, 1);
        chk("lh_mis_fault", r_flt, 1);
        chk("lh_mis_no_req", r_nreq, 0);

        run_op(LOAD, 3'd3, 32'h2000, 32'h0, 32'h0, 1, 0);
        chk("ld_f3_illegal", {r_flt, r_nreq[7:0]}, 9'h100);
        run_op(STORE, F3_BU, 32'h2000, 32'h0, 32'h0, 1, 0);
        chk("st_f3_illegal", {r_flt, r_nreq[7:0]}, 9'h100);

        run_op(LOAD, F3_HU, 32'h2002, 32'h0, 32'hBEEF_0000, 1, 0);
        chk("lhu_data", d_ld, 32'h0000_BEEF);
        run_op(LOAD, F3_H, 32'h2002, 32'h0, 32'hBEEF_0000, 1, 0);
        chk("lh_data", d_ld, 32'hFFFF_BEEF);

        run_op(STORE, F3_W, 32'h1004, 32'hDEAD_BEEF, 32'h0, 6, 3);
        chk("sw_req_cycles", r_nreq, 6);
        chk("sw_stable", r_stable, 1);
        chk("sw_done_cycle", r_dc, 7);
        chk("sw_fault", r_flt, 0);
        chk("sw_strb_wdata", {r_strb, r_wdata}, {4'b1111, 32'hDEAD_BEEF});
        chk("sw_mid_start_ignored", r_idle, 1);
        chk("sw_ld_kept", d_ld, 32'hFFFF_BEEF);

        opcode = 7'b0110011; start_d = 1'b1;
        tick();
        start_d = 1'b0;
        chk("nonmem_ignored", {d_busy, d_done}, 0);

        sel = 1'b1;
        run_op(LOAD, F3_W, 32'h0, 32'h0, 32'h0, -1, 0);
        chk("to_req_cycles", r_nreq, 4);
        chk("to_done_cycle", r_dc, 5);
        chk("to_fault", r_flt, 1);
        run_op(LOAD, F3_W, 32'h0, 32'h0, 32'h0, 4, 0);
        chk("to_ack_wins_req", r_nreq, 4);
        chk("to_ack_wins_fault", {r_dc[7:0], r_flt}, {8'd5, 1'b0});
        sel = 1'b0;

        opcode = LOAD; funct3 = F3_W; addr = 32'h4000; start_d = 1'b1;
        tick();
        start_d = 1'b0;
        chk("rst_mid_req_before", d_req, 1);
        #1 rst = 1'b1;
        #1 chk("rst_mid_req_drop", {d_req, d_busy}, 0);
        tick();
        chk("rst_mid_no_done", d_done, 0);
        rst = 1'b0;
        run_op(LOAD, F3_W, 32'h4000, 32'h0, 32'h1234_5678, 1, 0);
        chk("post_rst_done_cycle", r_dc, 2);
        chk("post_rst_ld", {31'h0, r_flt} ^ d_ld, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one parameter, TIMEOUT_CYCLES, default 255: the maximum number of cycles ACCESS waits for mem_ack before faulting.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  execute stage presents a memory operation this cycle.
REQ-005 opcode  input  7  instruction opcode (0000011 load, 0100011 store).
REQ-006 funct3  input  3  access size/signedness.
REQ-007 addr  input  32  effective address from the ALU.
REQ-008 store_data  input  32  rs2 value for stores.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse: operation complete.
REQ-011 fault  output  1  one-cycle pulse, coincident with done: misaligned, illegal funct3 or timeout.
REQ-012 load_data  output  32  extended load result; valid when done=1 and fault=0.
REQ-013 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-014 mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-015 mem_wstrb  output  4  byte-lane strobes; mem_wdata output 32  lane-replicated write data.
REQ-016 mem_rdata  input  32  read word; mem_ack input 1  memory accepts or completes the request.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-018 IDLE: start=1 with a load or store opcode SHALL latch opcode, funct3, addr and store_data. Legal and aligned goes to ACCESS. Otherwise go to RESP with the fault flag set.
REQ-019 start with any other opcode, or start while busy=1, SHALL be ignored with no done.
REQ-020 Legal funct3: loads 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU); stores 0 (SB), 1 (SH), 2 (SW). All other values SHALL fault.
REQ-021 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. A violation SHALL fault, and mem_req SHALL never assert for that operation.
REQ-022 ACCESS: mem_req=1, with mem_addr, mem_we, mem_wstrb and mem_wdata held stable until a cycle with mem_ack=1.
REQ-023 On mem_ack, load data SHALL be captured from mem_rdata and the FSM SHALL move to RESP; mem_req SHALL deassert the following cycle.
REQ-024 Strobes: SB 0001<<addr[1:0]; SH 0011 if addr[1]=0, else 1100; SW 1111. Loads drive mem_wstrb=0000 and mem_we=0.
REQ-025 Write data: SB {4{byte}}, SH {2{half}}, SW word.
REQ-026 Load extraction SHALL select the byte or halfword lane by addr[1:0]. LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
REQ-027 A wait counter SHALL clear on entry to ACCESS and increment each cycle without mem_ack. On reaching TIMEOUT_CYCLES the FSM SHALL go to RESP with fault set, and mem_req SHALL drop.
REQ-028 A mem_ack arriving in the same cycle the counter reaches its limit SHALL win, and no fault is raised.
REQ-029 RESP: done=1 for exactly one cycle, then IDLE. A start in RESP SHALL be ignored.
REQ-030 Minimum latency: start in cycle 0, ACCESS in cycle 1, with ack in cycle 1 done in cycle 2. A fault detected at start gives done in cycle 1.
REQ-031 load_data SHALL hold its last value until the next completed load. On a faulted or store operation, load_data SHALL be unchanged.
REQ-032 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-033 While rst=1: state IDLE; busy, done, fault, mem_req, mem_we = 0; mem_wstrb = 0000; mem_addr, mem_wdata, load_data = 0; counter = 0.
REQ-034 Reset during ACCESS SHALL drop mem_req immediately (asynchronously), with no done.
REQ-035 The first start SHALL be accepted in the first clock edge after rst deasserts.

Structure
REQ-036 Package lsu_pkg SHALL hold the opcode constants (LOAD, STORE), the funct3 encodings and the state enum.
REQ-037 One combinational sub-module, lsu_align, SHALL generate strobes and write data and perform load extraction and extension; the FSM and counter stay in load_store_unit.

Verification
REQ-038 SB: addr=0x1003, store_data=0xAB, ack in cycle 1 -> mem_addr=0x1000, mem_wstrb=1000, mem_wdata=0xABABABAB, done in cycle 2.
REQ-039 LB: addr=0x2001, mem_rdata=0x0000_8000 -> load_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-040 LW: addr=0x2002 -> fault and done in cycle 1, mem_req never asserted. LH: addr=0x2003 -> same result.
REQ-041 SW with ack delayed 5 cycles -> request fields stable for 6 cycles, then done; a start issued mid-wait is ignored.
REQ-042 TIMEOUT_CYCLES=4, no ack -> mem_req high for 4 cycles, then done with fault. A second run with ack on cycle 4 -> no fault.
REQ-043 Assert rst during ACCESS -> mem_req=0 the same cycle, no done; the next LW completes normally.
